booth_control_unit: RTL

//  Moore FSM that sequences the radix-2 Booth multiplier datapath (A/Q/Q-1/M regs, adder, shifter, iteration counter).

---
 rtl/booth_pkg.sv | 67 ++++++
 rtl/booth_iter_cnt.sv | 41 ++++
 rtl/booth_control_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier control unit.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package booth_pkg;

  // Default number of Booth iterations (operand width).
  localparam int DEFAULT_ITER = 8;

  // One-hot state bit positions.
  localparam int S_IDLE_IX  = 0;
  localparam int S_LOADM_IX = 1;
  localparam int S_LOADQ_IX = 2;
  localparam int S_CHECK_IX = 3;
  localparam int S_ADD_IX   = 4;
  localparam int S_SUB_IX   = 5;
  localparam int S_SHIFT_IX = 6;
  localparam int S_OUTA_IX  = 7;
  localparam int S_OUTQ_IX  = 8;
  localparam int S_DONE_IX  = 9;
  localparam int NUM_STATES = 10;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE   = 10'b00_0000_0001,
    S_LOAD_M = 10'b00_0000_0010,
    S_LOAD_Q = 10'b00_0000_0100,
    S_CHECK  = 10'b00_0000_1000,
    S_ADD    = 10'b00_0001_0000,
    S_SUB    = 10'b00_0010_0000,
    S_SHIFT  = 10'b00_0100_0000,
    S_OUT_A  = 10'b00_1000_0000,
    S_OUT_Q  = 10'b01_0000_0000,
    S_DONE   = 10'b10_0000_0000
  } state_t;

  // Control strobe indices within the ctrl vector.
  localparam int C0 = 0;
  localparam int C1 = 1;
  localparam int C2 = 2;
  localparam int C3 = 3;
  localparam int C4 = 4;
  localparam int C5 = 5;
  localparam int C6 = 6;
  localparam int NUM_CTRL = 7;

  typedef logic [NUM_CTRL-1:0] ctrl_t;

  // Strobes asserted while the FSM sits in state s (Moore decode).
  function automatic ctrl_t ctrl_for_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD_M: c[C0] = 1'b1;
      S_LOAD_Q: c[C1] = 1'b1;
      S_ADD:    c[C2] = 1'b1;
      S_SUB: begin
        c[C2] = 1'b1;
        c[C3] = 1'b1;
      end
      S_SHIFT:  c[C4] = 1'b1;
      S_OUT_A:  c[C5] = 1'b1;
      S_OUT_Q:  c[C6] = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: cleared on operand load, bumped on each shift, flags the final iteration.
// Latency: cnt updates on the clock edge after clr/inc; last is combinational from the count.
// Backpressure: none; clr has priority over inc, count saturates at ITER-1 so it never wraps.
module booth_iter_cnt #(
  parameter int ITER = 8
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(ITER - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last = (cnt_q == LAST_VAL);

  // Next count: clear wins, otherwise step once per shift, holding at the final value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/booth_control_unit.sv
// Moore FSM sequencing the radix-2 Booth datapath via registered one-hot strobes c0..c6.
// Latency: start at edge k gives c0 in cycle k+1; a run is 2 + sum(2 or 3 per iteration) + 3 cycles.
// Backpressure: none; start is only sampled in IDLE and is otherwise dropped (no queuing).
module booth_control_unit
  import booth_pkg::*;
#(
  parameter int ITER = DEFAULT_ITER
) (
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  input  logic q0,
  input  logic q_m1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic busy,
  output logic done
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;
  logic   busy_q;
  logic   busy_d;
  logic   done_q;
  logic   done_d;
  logic   cnt_last;
  logic   cnt_clr;
  logic   cnt_inc;

  // The counter follows the current state: cleared while loading M, stepped as each shift retires.
  assign cnt_clr = (state_q == S_LOAD_M);
  assign cnt_inc = (state_q == S_SHIFT);

  booth_iter_cnt #(
    .ITER (ITER)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (cnt_last)
  );

  // Next state plus the outputs that state will present; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = start ? S_LOAD_M : S_IDLE;
      S_LOAD_M: state_d = S_LOAD_Q;
      S_LOAD_Q: state_d = S_CHECK;
      S_CHECK: begin
        case ({q0, q_m1})
          2'b01:   state_d = S_ADD;
          2'b10:   state_d = S_SUB;
          default: state_d = S_SHIFT;
        endcase
      end
      S_ADD:    state_d = S_SHIFT;
      S_SUB:    state_d = S_SHIFT;
      S_SHIFT:  state_d = cnt_last ? S_OUT_A : S_CHECK;
      S_OUT_A:  state_d = S_OUT_Q;
      S_OUT_Q:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    ctrl_d = ctrl_for_state(state_d);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; outputs come straight from flops so no input reaches them combinationally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign c0   = ctrl_q[C0];
  assign c1   = ctrl_q[C1];
  assign c2   = ctrl_q[C2];
  assign c3   = ctrl_q[C3];
  assign c4   = ctrl_q[C4];
  assign c5   = ctrl_q[C5];
  assign c6   = ctrl_q[C6];
  assign busy = busy_q;
  assign done = done_q;

endmodule
